// File: rtl/matrix_read_streamer.sv
// matrix_read_streamer
//   Reads one matrix from the storage manager and replays its elements as a
//   valid/ready stream. A start pulse latches the matrix ID. The block then
//   issues a read request and captures the metadata (rows, cols, name). It
//   then pulls rows*cols words one at a time into a small output FIFO.
//   Only one word request is outstanding at a time, and a request is issued
//   only when the FIFO has a free slot. This keeps the block independent of
//   the manager's read latency and makes FIFO overflow impossible.
//
//   Optional feature macro: MRS_ROW_LAST_EN
//     When defined, the block adds the m_row_last output. This flag is stored
//     with each FIFO entry and marks the last element of each row.
//
// Parameters
//   DATA_WIDTH  element width (matches the manager's read_data_out)
//   FIFO_DEPTH  output buffer entries; must be a power of 2 and >= 2
//
// Ports
//   clk, rst_n          clock and asynchronous active-low reset
//   start, matrix_id    request a transfer (start is sampled only when idle)
//   busy, done, err     status; done and err are 1-cycle pulses
//   meta_*              captured metadata; meta_valid stays high until the
//                       next accepted start
//   m_data/m_valid/m_ready/m_last   output stream (m_last marks the final
//                       element of the matrix)
//   m_row_last          end-of-row flag (present only with MRS_ROW_LAST_EN)
//   read_*              storage-manager read interface
module matrix_read_streamer #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2:0]            matrix_id,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [7:0]            meta_rows,
  output logic [7:0]            meta_cols,
  output logic [63:0]           meta_name,
  output logic                  meta_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
`ifdef MRS_ROW_LAST_EN
  output logic                  m_row_last,
`endif
  output logic                  read_req,
  output logic [2:0]            read_matrix_id,
  output logic                  read_data_req,
  input  logic                  reader_ready,
  input  logic                  read_meta_valid,
  input  logic [7:0]            read_rows,
  input  logic [7:0]            read_cols,
  input  logic [63:0]           read_matrix_name,
  input  logic [DATA_WIDTH-1:0] read_data_out,
  input  logic                  read_data_valid,
  input  logic                  read_done
);

  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_META,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        state_q;
  logic          read_req_q;
  logic          read_data_req_q;
  logic [2:0]    read_matrix_id_q;
  logic          done_q;
  logic          err_q;
  logic          meta_valid_q;
  logic [7:0]    meta_rows_q;
  logic [7:0]    meta_cols_q;
  logic [63:0]   meta_name_q;
  logic [15:0]   remaining_q;
  logic          outstanding_q;
  logic [15:0]   meta_total;

  // FIFO state
  logic [AW-1:0]         wr_ptr_q;
  logic [AW-1:0]         rd_ptr_q;
  logic [AW:0]           count_q;
  logic [AW:0]           count_d;
  logic [DATA_WIDTH-1:0] data_mem [FIFO_DEPTH];
  logic                  last_mem [FIFO_DEPTH];
  logic                  push;
  logic                  pop;
  logic                  fifo_nonempty;

  assign meta_total    = {8'd0, read_rows} * {8'd0, read_cols};
  assign fifo_nonempty = (count_q != '0);

  // A returned word is accepted only while a request is outstanding.
  // Stray read_data_valid pulses are dropped.
  assign push    = (state_q == S_STREAM) && outstanding_q && read_data_valid;
  assign pop     = fifo_nonempty && m_ready;
  assign count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);

  // Control FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      read_req_q       <= 1'b0;
      read_data_req_q  <= 1'b0;
      read_matrix_id_q <= 3'd0;
      done_q           <= 1'b0;
      err_q            <= 1'b0;
      meta_valid_q     <= 1'b0;
      meta_rows_q      <= 8'd0;
      meta_cols_q      <= 8'd0;
      meta_name_q      <= 64'd0;
      remaining_q      <= 16'd0;
      outstanding_q    <= 1'b0;
    end else begin
      read_req_q      <= 1'b0;
      read_data_req_q <= 1'b0;
      done_q          <= 1'b0;
      err_q           <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            read_matrix_id_q <= matrix_id;
            meta_valid_q     <= 1'b0;
            state_q          <= S_REQ;
          end
        end
        S_REQ: begin
          if (reader_ready) begin
            read_req_q <= 1'b1;
            state_q    <= S_META;
          end
        end
        S_META: begin
          if (read_meta_valid) begin
            meta_rows_q  <= read_rows;
            meta_cols_q  <= read_cols;
            meta_name_q  <= read_matrix_name;
            meta_valid_q <= 1'b1;
            remaining_q  <= meta_total;
            if (meta_total == 16'd0) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              state_q <= S_STREAM;
            end
          end
        end
        S_STREAM: begin
          if (push) begin
            outstanding_q <= 1'b0;
            remaining_q   <= remaining_q - 16'd1;
            if (remaining_q == 16'd1) begin
              state_q <= S_DRAIN;
            end
          end else if (!outstanding_q) begin
            // With no word in flight, the manager ending early is an error.
            // Otherwise the next word is requested as soon as a FIFO slot
            // is free.
            if (remaining_q == 16'd0) begin
              state_q <= S_DRAIN;
            end else if (read_done) begin
              err_q   <= 1'b1;
              state_q <= S_DRAIN;
            end else if (count_q < DEPTH_C) begin
              read_data_req_q <= 1'b1;
              outstanding_q   <= 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (!fifo_nonempty) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_d;
    end
  end

  // FIFO storage; the last flag marks the push that drains remaining to zero
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_q] <= read_data_out;
      last_mem[wr_ptr_q] <= (remaining_q == 16'd1);
    end
  end

`ifdef MRS_ROW_LAST_EN
  // The column counter restarts with each matrix. It wraps after the
  // entry that closes a row.
  logic [7:0] col_q;
  logic       push_row_last;
  logic       row_mem [FIFO_DEPTH];

  assign push_row_last = (col_q == (meta_cols_q - 8'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= 8'd0;
    end else if ((state_q == S_META) && read_meta_valid) begin
      col_q <= 8'd0;
    end else if (push) begin
      col_q <= push_row_last ? 8'd0 : (col_q + 8'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      row_mem[wr_ptr_q] <= push_row_last;
    end
  end

  assign m_row_last = fifo_nonempty && row_mem[rd_ptr_q];
`endif

  // Stream outputs are gated to zero while the FIFO is empty, so that
  // reset and idle both present an all-zero interface.
  assign m_valid = fifo_nonempty;
  assign m_data  = fifo_nonempty ? data_mem[rd_ptr_q] : '0;
  assign m_last  = fifo_nonempty && last_mem[rd_ptr_q];

  assign busy           = (state_q != S_IDLE);
  assign done           = done_q;
  assign err            = err_q;
  assign meta_rows      = meta_rows_q;
  assign meta_cols      = meta_cols_q;
  assign meta_name      = meta_name_q;
  assign meta_valid     = meta_valid_q;
  assign read_req       = read_req_q;
  assign read_matrix_id = read_matrix_id_q;
  assign read_data_req  = read_data_req_q;

endmodule
